// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle PASS/ADD/ADC/SETC/CLRC/NOP plus a multi-cycle
// shift-and-add multiply of the low halves of A and B.
module alu_seq #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] alu_out,
   output logic             carryflg,
   output logic             zeroflg
);

   localparam int unsigned H  = WIDTH / 2;
   localparam int unsigned CW = $clog2(H + 1);

   localparam logic [2:0] OpPass = 3'b000;
   localparam logic [2:0] OpAdd  = 3'b001;
   localparam logic [2:0] OpAdc  = 3'b010;
   localparam logic [2:0] OpMult = 3'b011;
   localparam logic [2:0] OpSetc = 3'b100;
   localparam logic [2:0] OpClrc = 3'b101;

   typedef enum logic [0:0] {StIdle, StMul} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [H-1:0]     mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             done_q, done_d;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] mul_acc;

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      out_d    = out_q;
      carry_d  = carry_q;
      zero_d   = zero_q;
      done_d   = 1'b0;
      sum      = '0;
      mul_acc  = acc_q + (mplier_q[0] ? mcand_q : '0);

      unique case (state_q)
         StIdle: begin
            if (start) begin
               done_d = 1'b1;
               case (op)
                  OpPass: begin
                     out_d  = A;
                     zero_d = (A == '0);
                  end
                  OpAdd, OpAdc: begin
                     sum = {1'b0, A} + {1'b0, B}
                           + {{WIDTH{1'b0}}, (op == OpAdc) & carry_q};
                     {carry_d, out_d} = sum;
                     zero_d = (sum[WIDTH-1:0] == '0);
                  end
                  OpMult: begin
                     done_d   = 1'b0;
                     mcand_d  = {{(WIDTH-H){1'b0}}, A[H-1:0]};
                     mplier_d = B[H-1:0];
                     acc_d    = '0;
                     cnt_d    = CW'(H);
                     state_d  = StMul;
                  end
                  OpSetc:  carry_d = 1'b1;
                  OpClrc:  carry_d = 1'b0;
                  default: ;
               endcase
            end
         end
         StMul: begin
            acc_d    = mul_acc;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            // Last iteration: the accumulated sum is the full 2H-bit product
            if (cnt_q == CW'(1)) begin
               out_d   = mul_acc;
               zero_d  = (mul_acc == '0);
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         out_q    <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         out_q    <= out_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
         done_q   <= done_d;
      end
   end

   assign ready    = (state_q == StIdle);
   assign done     = done_q;
   assign alu_out  = out_q;
   assign carryflg = carry_q;
   assign zeroflg  = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_alu_seq;

   localparam int unsigned W = 16;
   localparam int unsigned H = W / 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] a, b;
   logic         ready, done, carryflg, zeroflg;
   logic [W-1:0] alu_out;
   logic [W+3:0] obs, exp_v;

   int errors = 0;
   int checks = 0;

   // Behavioural model state
   int unsigned  m_busy;
   logic [W-1:0] m_out, m_prod;
   logic         m_c, m_z, m_done;

   alu_seq #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .A        (a),
      .B        (b),
      .ready    (ready),
      .done     (done),
      .alu_out  (alu_out),
      .carryflg (carryflg),
      .zeroflg  (zeroflg)
   );

   always #5 clk = ~clk;

   assign obs = {ready, done, carryflg, zeroflg, alu_out};

   function automatic void model_reset();
      m_busy = 0;
      m_out  = '0;
      m_prod = '0;
      m_c    = 1'b0;
      m_z    = 1'b0;
      m_done = 1'b0;
   endfunction

   // Predicts the outputs seen after the next rising edge given current inputs
   function automatic void model_step(input logic s, input logic [2:0] o,
                                      input logic [W-1:0] x, input logic [W-1:0] y);
      int unsigned ux, uy, tot;
      ux = x;
      uy = y;
      m_done = 1'b0;
      if (m_busy == 0) begin
         if (s) begin
            m_done = (o != 3'd3);
            case (o)
               3'd0: begin
                  m_out = x;
                  m_z   = (ux == 0);
               end
               3'd1, 3'd2: begin
                  tot   = ux + uy + ((o == 3'd2 && m_c) ? 1 : 0);
                  m_c   = (tot >= (1 << W));
                  m_out = W'(tot % (1 << W));
                  m_z   = ((tot % (1 << W)) == 0);
               end
               3'd3: begin
                  m_busy = H;
                  m_prod = W'((ux % (1 << H)) * (uy % (1 << H)));
               end
               3'd4: m_c = 1'b1;
               3'd5: m_c = 1'b0;
               default: ;
            endcase
         end
      end else begin
         m_busy = m_busy - 1;
         if (m_busy == 0) begin
            m_out  = m_prod;
            m_z    = (m_prod == '0);
            m_done = 1'b1;
         end
      end
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 3))
         0:       return '0;
         1:       return '1;
         default: return W'($urandom);
      endcase
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      op    = 3'd0;
      a     = '0;
      b     = '0;
      @(negedge clk);
      checks++;
      if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000})
         $display("FAIL reset_state: got %h expected %h", obs,
                  {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
      if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) errors++;
      rst_n = 1'b1;
   endtask

   // ADD/ADC, MULT with ignored busy start, SETC/PASS/CLRC
   task automatic test_directed();
      start = 1'b1; op = 3'd1; a = 16'hFFFF; b = 16'h0001;
      @(negedge clk);
      checks++;
      if (obs !== {1'b1, 1'b1, 1'b1, 1'b1, 16'h0000}) begin
         errors++;
         $display("FAIL add_wrap: got %h expected %h", obs, {1'b1, 1'b1, 1'b1, 1'b1, 16'h0000});
      end
      op = 3'd2; a = 16'h0001; b = 16'h0001;
      @(negedge clk);
      checks++;
      if (obs !== {1'b1, 1'b1, 1'b0, 1'b0, 16'h0003}) begin
         errors++;
         $display("FAIL adc: got %h expected %h", obs, {1'b1, 1'b1, 1'b0, 1'b0, 16'h0003});
      end
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0003}) begin
         errors++;
         $display("FAIL done_one_cycle: got %h expected %h", obs,
                  {1'b1, 1'b0, 1'b0, 1'b0, 16'h0003});
      end
      start = 1'b1; op = 3'd3; a = 16'h12FF; b = 16'h34FF;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         // busy-cycle request must be ignored; operand changes must not leak in
         op = 3'd1; a = 16'hFFFF; b = 16'hFFFF;
         checks++;
         if ({ready, done} !== 2'b00) begin
            errors++;
            $display("FAIL mult_busy_%0d: got %b expected 00", i, {ready, done});
         end
      end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (obs !== {1'b1, 1'b1, 1'b0, 1'b0, 16'hFE01}) begin
         errors++;
         $display("FAIL mult_result: got %h expected %h", obs, {1'b1, 1'b1, 1'b0, 1'b0, 16'hFE01});
      end
      start = 1'b1; op = 3'd4;
      @(negedge clk);
      checks++;
      if (obs !== {1'b1, 1'b1, 1'b1, 1'b0, 16'hFE01}) begin
         errors++;
         $display("FAIL setc: got %h expected %h", obs, {1'b1, 1'b1, 1'b1, 1'b0, 16'hFE01});
      end
      op = 3'd0; a = 16'h1234;
      @(negedge clk);
      checks++;
      if (obs !== {1'b1, 1'b1, 1'b1, 1'b0, 16'h1234}) begin
         errors++;
         $display("FAIL pass: got %h expected %h", obs, {1'b1, 1'b1, 1'b1, 1'b0, 16'h1234});
      end
      op = 3'd5;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (obs !== {1'b1, 1'b1, 1'b0, 1'b0, 16'h1234}) begin
         errors++;
         $display("FAIL clrc: got %h expected %h", obs, {1'b1, 1'b1, 1'b0, 1'b0, 16'h1234});
      end
   endtask

   task automatic test_reset_mid_mul();
      start = 1'b1; op = 3'd4;
      @(negedge clk);
      op = 3'd3; a = 16'h0003; b = 16'h0005;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      // Assert reset while the clock is low: only an asynchronous clear acts here
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
         errors++;
         $display("FAIL async_reset: got %h expected %h", obs, {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL no_done_after_abort_%0d: got %h expected %h", i, obs,
                     {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
         end
      end
   endtask

   task automatic test_back_to_back();
      int dcount;
      dcount = 0;
      model_reset();
      for (int i = 0; i < 18; i++) begin
         if (i < 4) begin
            start = 1'b1; op = 3'd1; a = pick(); b = pick();
         end else if (i == 4) begin
            start = 1'b1; op = 3'd3; a = pick(); b = pick();
         end else begin
            start = 1'b0; a = pick(); b = pick();
         end
         model_step(start, op, a, b);
         @(negedge clk);
         exp_v = {(m_busy == 0), m_done, m_c, m_z, m_out};
         if (done) dcount++;
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL b2b_cycle_%0d: got %h expected %h", i, obs, exp_v);
         end
      end
      checks++;
      if (dcount != 5) begin
         errors++;
         $display("FAIL b2b_done_count: got %0d expected 5", dcount);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 420; i++) begin
         start = (i < 400) && ($urandom_range(0, 9) < 7);
         op    = 3'($urandom_range(0, 7));
         a     = pick();
         b     = pick();
         model_step(start, op, a, b);
         @(negedge clk);
         exp_v = {(m_busy == 0), m_done, m_c, m_z, m_out};
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL random_cycle_%0d: got %h expected %h", i, obs, exp_v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_reset_mid_mul();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
